// File: rtl/aes2_cbc_sequencer.sv
// rtl/aes2_cbc_sequencer.sv - ECB/CBC block sequencer between a 128-bit stream and the AES2 core
// One block in flight: accept, run core, wait for core to drop valid, present result.
module aes2_cbc_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             mode_i,
   input  logic [127:0]     iv_i,
   input  logic             iv_load_i,
   input  logic             abort_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [127:0]     in_data_i,
   input  logic             in_last_i,
   output logic             core_start_o,
   output logic [127:0]     core_pc_o,
   input  logic [127:0]     core_ct_i,
   input  logic             core_ct_valid_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [127:0]     out_data_o,
   output logic             out_last_o,
   output logic             busy_o,
   output logic             err_o,
   input  logic             err_clr_i,
   output logic [CNT_W-1:0] blk_cnt_o
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [127:0]     iv_q;
   logic [127:0]     chain_q;
   logic [127:0]     pc_q;
   logic [127:0]     res_q;
   logic             mode_q;
   logic             last_q;
   logic             res_last_q;
   logic             pend_q;
   logic [TMO_W-1:0] tmo_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q;
   logic             start_q;
   logic             out_valid_q;
   logic             busy_q;

   logic in_fire;
   logic ct_fire;
   logic tmo_fire;
   logic out_fire;
   logic iv_load_ok;

   // Abort outranks every handshake, including one offered in IDLE.
   always_comb begin
      state_d  = state_q;
      in_fire  = 1'b0;
      ct_fire  = 1'b0;
      tmo_fire = 1'b0;
      out_fire = 1'b0;
      if (abort_i) begin
         state_d = core_ct_valid_i ? S_DRAIN : S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid_i) begin
                  in_fire = 1'b1;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (core_ct_valid_i) begin
                  ct_fire = 1'b1;
                  state_d = S_DRAIN;
               end else if (tmo_q == TMO_LAST) begin
                  tmo_fire = 1'b1;
                  state_d  = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!core_ct_valid_i) begin
                  state_d = pend_q ? S_OUT : S_IDLE;
               end
            end
            S_OUT: begin
               if (out_ready_i) begin
                  out_fire = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign iv_load_ok = iv_load_i && (state_q == S_IDLE);

   // Handshake/status outputs are flops decoded from the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in_ready_q  <= 1'b1;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         in_ready_q  <= (state_d == S_IDLE);
         start_q     <= (state_d == S_RUN);
         out_valid_q <= (state_d == S_OUT);
         busy_q      <= (state_d != S_IDLE);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iv_q       <= '0;
         chain_q    <= '0;
         pc_q       <= '0;
         res_q      <= '0;
         mode_q     <= 1'b0;
         last_q     <= 1'b0;
         res_last_q <= 1'b0;
         pend_q     <= 1'b0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (iv_load_ok) begin
            iv_q <= iv_i;
         end

         // A same-cycle IV load wins the chain; the block XOR above already used the old value.
         if (iv_load_ok) begin
            chain_q <= iv_i;
         end else if (abort_i || tmo_fire || (out_fire && last_q)) begin
            chain_q <= iv_q;
         end else if (ct_fire && mode_q) begin
            chain_q <= core_ct_i;
         end

         if (in_fire) begin
            pc_q   <= in_data_i ^ (mode_i ? chain_q : 128'd0);
            mode_q <= mode_i;
            last_q <= in_last_i;
         end

         if (ct_fire) begin
            res_q      <= core_ct_i;
            res_last_q <= last_q;
         end

         if (abort_i || in_fire) begin
            pend_q <= 1'b0;
         end else if (ct_fire) begin
            pend_q <= 1'b1;
         end

         if (state_q == S_RUN) begin
            tmo_q <= tmo_q + TMO_W'(1);
         end else begin
            tmo_q <= '0;
         end

         if (tmo_fire) begin
            err_q <= 1'b1;
         end else if (err_clr_i) begin
            err_q <= 1'b0;
         end

         if (out_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign in_ready_o   = in_ready_q;
   assign core_start_o = start_q;
   assign core_pc_o    = pc_q;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = res_q;
   assign out_last_o   = res_last_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;
   assign blk_cnt_o    = cnt_q;

endmodule
